cpu_datamem_arbiter: RTL and testbench



---
 rtl/cpu_datamem_arb_pkg.sv | 27 ++
 rtl/cpu_datamem_arb_core.sv | 109 ++++++++++
 rtl/cpu_datamem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_cpu_datamem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_datamem_arb_pkg.sv
// Shared types, widths and helpers for the CPU data-memory arbiter.
//   req_e        : identifies a requester (CPU load/store unit or SHA accelerator)
//   ADDR_W ...   : bus widths of the data memory
//   in_range()   : 1 when an access of nbytes starting at addr stays inside 64 KiB
package cpu_datamem_arb_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_ACC = 1'b1
    } req_e;

    localparam int          ADDR_W       = 16;
    localparam int          WDATA_W      = 32;
    localparam int          LINE_W       = 512;
    localparam int unsigned CPU_RD_BYTES = 32'd4;
    localparam int unsigned ACC_RD_BYTES = 32'd64;
    localparam int unsigned WR_BYTES     = 32'd4;

    // The last byte touched is addr + nbytes - 1; it must not pass 0xFFFF.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       nbytes);
        logic [31:0] end_s;
        end_s = {16'h0000, addr} + nbytes;
        return (end_s <= 32'h0001_0000);
    endfunction

endpackage

// File: rtl/cpu_datamem_arb_core.sv
// Grant decision for the shared data memory, plus the arbitration state.
//   clk, rst_n         : clock, asynchronous active-low reset
//   cpu_req, acc_req   : access requests
//   acc_lock           : accelerator asks to keep the grant for a burst
//   cpu_gnt, acc_gnt   : combinational one-hot grant for this cycle
// State: last_gnt (who won last), lock_cnt (accelerator grants taken under
// lock while the CPU waited), starve_cnt (cycles the CPU has waited).
module cpu_datamem_arb_core
    import cpu_datamem_arb_pkg::*;
#(
    parameter int MAX_LOCK     = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req,
    input  logic acc_req,
    input  logic acc_lock,
    output logic cpu_gnt,
    output logic acc_gnt
);

    localparam int LOCK_W   = $clog2(MAX_LOCK + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LOCK_W-1:0]   LOCK_MAX   = LOCK_W'(MAX_LOCK);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [LOCK_W-1:0]   LOCK_ONE   = LOCK_W'(1);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    req_e                last_gnt_r, last_gnt_s;
    logic [LOCK_W-1:0]   lock_cnt_r, lock_cnt_s;
    logic [STARVE_W-1:0] starve_cnt_r, starve_cnt_s;
    logic                cpu_gnt_s, acc_gnt_s;

    // Fixed-order priority: starvation guard, accelerator lock, round-robin, single requester.
    always_comb begin
        cpu_gnt_s = 1'b0;
        acc_gnt_s = 1'b0;
        if (cpu_req && (starve_cnt_r == STARVE_MAX)) begin
            cpu_gnt_s = 1'b1;
        end else if (acc_req && acc_lock && (last_gnt_r == REQ_ACC) && (lock_cnt_r < LOCK_MAX)) begin
            acc_gnt_s = 1'b1;
        end else if (cpu_req && acc_req) begin
            if (last_gnt_r == REQ_CPU) begin
                acc_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s = 1'b1;
            end
        end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (acc_req) begin
            acc_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            acc_gnt_s = 1'b0;
        end
    end

    // Next-state of the arbitration counters and last-winner flag.
    always_comb begin
        last_gnt_s   = last_gnt_r;
        lock_cnt_s   = lock_cnt_r;
        starve_cnt_s = starve_cnt_r;

        if (cpu_gnt_s) begin
            last_gnt_s = REQ_CPU;
        end else if (acc_gnt_s) begin
            last_gnt_s = REQ_ACC;
        end else begin
            last_gnt_s = last_gnt_r;
        end

        // Waiting is only counted while the CPU actually has a request up.
        if (!cpu_req || cpu_gnt_s) begin
            starve_cnt_s = {STARVE_W{1'b0}};
        end else if (starve_cnt_r != STARVE_MAX) begin
            starve_cnt_s = starve_cnt_r + STARVE_ONE;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end

        // Lock budget is only consumed while the CPU is being held off,
        // so an uncontended locked burst never expires.
        if (!acc_lock || cpu_gnt_s) begin
            lock_cnt_s = {LOCK_W{1'b0}};
        end else if (acc_gnt_s && cpu_req && (lock_cnt_r != LOCK_MAX)) begin
            lock_cnt_s = lock_cnt_r + LOCK_ONE;
        end else begin
            lock_cnt_s = lock_cnt_r;
        end
    end

    // Arbitration state registers; last_gnt starts at ACC so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r   <= REQ_ACC;
            lock_cnt_r   <= {LOCK_W{1'b0}};
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else begin
            last_gnt_r   <= last_gnt_s;
            lock_cnt_r   <= lock_cnt_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

    assign cpu_gnt = cpu_gnt_s;
    assign acc_gnt = acc_gnt_s;

endmodule

// File: rtl/cpu_datamem_arbiter.sv
// Shares the single-port CPU data memory between the CPU load/store unit and
// the SHA accelerator: one access per cycle, range check, read return.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       : CPU request (held until cpu_gnt)
//   cpu_gnt/rvalid/rdata/err    : CPU grant (combinational), read/error return
//   acc_req/we/addr/wdata/lock  : accelerator request, lock keeps bursts together
//   acc_gnt/rvalid/rdata/err    : accelerator grant, 512-bit read/error return
//   mem_addr/wrt_data/wrt_en    : to the data memory
//   mem_rd_data                 : registered 512-bit line from the data memory
// Optional build macro ARB_PERF_CNT_EN adds perf_clr and saturating counters
// cpu_gnt_cnt, acc_gnt_cnt, cpu_wait_cnt.
module cpu_datamem_arbiter
    import cpu_datamem_arb_pkg::*;
#(
    parameter int MAX_LOCK     = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WDATA_W-1:0] cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [WDATA_W-1:0] cpu_rdata,
    output logic               cpu_err,
    input  logic               acc_req,
    input  logic               acc_we,
    input  logic [ADDR_W-1:0]  acc_addr,
    input  logic [WDATA_W-1:0] acc_wdata,
    input  logic               acc_lock,
    output logic               acc_gnt,
    output logic               acc_rvalid,
    output logic [LINE_W-1:0]  acc_rdata,
    output logic               acc_err,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_wrt_data,
    output logic               mem_wrt_en,
    input  logic [LINE_W-1:0]  mem_rd_data
`ifdef ARB_PERF_CNT_EN
    ,
    input  logic               perf_clr,
    output logic [31:0]        cpu_gnt_cnt,
    output logic [31:0]        acc_gnt_cnt,
    output logic [31:0]        cpu_wait_cnt
`endif
);

    logic               cpu_gnt_s, acc_gnt_s;
    logic               cpu_ok_s, acc_ok_s;
    logic               cpu_rvalid_r, cpu_err_r;
    logic               acc_rvalid_r, acc_err_r;
    logic [WDATA_W-1:0] cpu_hold_r;
    logic [LINE_W-1:0]  acc_hold_r;

    cpu_datamem_arb_core #(
        .MAX_LOCK     (MAX_LOCK),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .acc_req  (acc_req),
        .acc_lock (acc_lock),
        .cpu_gnt  (cpu_gnt_s),
        .acc_gnt  (acc_gnt_s)
    );

    // Range check of each requester's current access; writes are always 4 bytes.
    always_comb begin
        cpu_ok_s = 1'b0;
        acc_ok_s = 1'b0;
        if (cpu_we) begin
            cpu_ok_s = in_range(cpu_addr, WR_BYTES);
        end else begin
            cpu_ok_s = in_range(cpu_addr, CPU_RD_BYTES);
        end
        if (acc_we) begin
            acc_ok_s = in_range(acc_addr, WR_BYTES);
        end else begin
            acc_ok_s = in_range(acc_addr, ACC_RD_BYTES);
        end
    end

    // Memory port mux; a rejected write never raises the write enable.
    always_comb begin
        mem_addr     = {ADDR_W{1'b0}};
        mem_wrt_data = {WDATA_W{1'b0}};
        mem_wrt_en   = 1'b0;
        if (cpu_gnt_s) begin
            mem_addr     = cpu_addr;
            mem_wrt_data = cpu_wdata;
            mem_wrt_en   = cpu_we & cpu_ok_s;
        end else if (acc_gnt_s) begin
            mem_addr     = acc_addr;
            mem_wrt_data = acc_wdata;
            mem_wrt_en   = acc_we & acc_ok_s;
        end else begin
            mem_addr     = {ADDR_W{1'b0}};
            mem_wrt_data = {WDATA_W{1'b0}};
            mem_wrt_en   = 1'b0;
        end
    end

    // Return strobes: good reads and every rejected access answer one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid_r <= 1'b0;
            cpu_err_r    <= 1'b0;
            acc_rvalid_r <= 1'b0;
            acc_err_r    <= 1'b0;
        end else begin
            cpu_rvalid_r <= cpu_gnt_s & (~cpu_we | ~cpu_ok_s);
            cpu_err_r    <= cpu_gnt_s & ~cpu_ok_s;
            acc_rvalid_r <= acc_gnt_s & (~acc_we | ~acc_ok_s);
            acc_err_r    <= acc_gnt_s & ~acc_ok_s;
        end
    end

    // Hold registers keep the last returned data visible after the rvalid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold_r <= {WDATA_W{1'b0}};
            acc_hold_r <= {LINE_W{1'b0}};
        end else begin
            if (cpu_rvalid_r) begin
                cpu_hold_r <= mem_rd_data[WDATA_W-1:0];
            end else begin
                cpu_hold_r <= cpu_hold_r;
            end
            if (acc_rvalid_r) begin
                acc_hold_r <= mem_rd_data;
            end else begin
                acc_hold_r <= acc_hold_r;
            end
        end
    end

    // The memory line is only valid during rvalid, so it is forwarded straight through then.
    assign cpu_rdata  = cpu_rvalid_r ? mem_rd_data[WDATA_W-1:0] : cpu_hold_r;
    assign acc_rdata  = acc_rvalid_r ? mem_rd_data : acc_hold_r;
    assign cpu_gnt    = cpu_gnt_s;
    assign acc_gnt    = acc_gnt_s;
    assign cpu_rvalid = cpu_rvalid_r;
    assign cpu_err    = cpu_err_r;
    assign acc_rvalid = acc_rvalid_r;
    assign acc_err    = acc_err_r;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] cpu_gnt_cnt_r, acc_gnt_cnt_r, cpu_wait_cnt_r;

    // Saturating grant and CPU wait counters, cleared by perf_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_gnt_cnt_r  <= 32'h0000_0000;
            acc_gnt_cnt_r  <= 32'h0000_0000;
            cpu_wait_cnt_r <= 32'h0000_0000;
        end else if (perf_clr) begin
            cpu_gnt_cnt_r  <= 32'h0000_0000;
            acc_gnt_cnt_r  <= 32'h0000_0000;
            cpu_wait_cnt_r <= 32'h0000_0000;
        end else begin
            if (cpu_gnt_s && (cpu_gnt_cnt_r != 32'hFFFF_FFFF)) begin
                cpu_gnt_cnt_r <= cpu_gnt_cnt_r + 32'd1;
            end else begin
                cpu_gnt_cnt_r <= cpu_gnt_cnt_r;
            end
            if (acc_gnt_s && (acc_gnt_cnt_r != 32'hFFFF_FFFF)) begin
                acc_gnt_cnt_r <= acc_gnt_cnt_r + 32'd1;
            end else begin
                acc_gnt_cnt_r <= acc_gnt_cnt_r;
            end
            if (cpu_req && !cpu_gnt_s && (cpu_wait_cnt_r != 32'hFFFF_FFFF)) begin
                cpu_wait_cnt_r <= cpu_wait_cnt_r + 32'd1;
            end else begin
                cpu_wait_cnt_r <= cpu_wait_cnt_r;
            end
        end
    end

    assign cpu_gnt_cnt  = cpu_gnt_cnt_r;
    assign acc_gnt_cnt  = acc_gnt_cnt_r;
    assign cpu_wait_cnt = cpu_wait_cnt_r;
`endif

endmodule

// File: tb/tb_cpu_datamem_arbiter.sv
// Directed bench for cpu_datamem_arbiter with a behavioural 64 KiB byte memory.
// A second instance with MAX_LOCK = 4 shares the stimulus so that lock expiry
// is observable; with the default parameters the starvation guard (8 cycles)
// always preempts the 16-grant lock budget.
module tb_cpu_datamem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_we, acc_req, acc_we, acc_lock;
    logic [15:0]  cpu_addr, acc_addr;
    logic [31:0]  cpu_wdata, acc_wdata;
    logic         cpu_gnt, cpu_rvalid, cpu_err, acc_gnt, acc_rvalid, acc_err;
    logic [31:0]  cpu_rdata;
    logic [511:0] acc_rdata;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wrt_data;
    logic         mem_wrt_en;
    logic [511:0] mem_rd_data;

    logic         lk_cpu_gnt, lk_cpu_rvalid, lk_cpu_err, lk_acc_gnt, lk_acc_rvalid, lk_acc_err;
    logic [31:0]  lk_cpu_rdata;
    logic [511:0] lk_acc_rdata;
    logic [15:0]  lk_mem_addr;
    logic [31:0]  lk_mem_wrt_data;
    logic         lk_mem_wrt_en;
`ifdef ARB_PERF_CNT_EN
    logic         perf_clr = 1'b0;
    logic [31:0]  cpu_gnt_cnt, acc_gnt_cnt, cpu_wait_cnt;
    logic [31:0]  lk_cpu_gnt_cnt, lk_acc_gnt_cnt, lk_cpu_wait_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    cpu_datamem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_lock(acc_lock),
        .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata), .acc_err(acc_err),
        .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en),
        .mem_rd_data(mem_rd_data)
`ifdef ARB_PERF_CNT_EN
        , .perf_clr(perf_clr), .cpu_gnt_cnt(cpu_gnt_cnt), .acc_gnt_cnt(acc_gnt_cnt),
        .cpu_wait_cnt(cpu_wait_cnt)
`endif
    );

    cpu_datamem_arbiter #(.MAX_LOCK(4), .STARVE_LIMIT(8)) dut_lk (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(lk_cpu_gnt), .cpu_rvalid(lk_cpu_rvalid), .cpu_rdata(lk_cpu_rdata),
        .cpu_err(lk_cpu_err),
        .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_lock(acc_lock),
        .acc_gnt(lk_acc_gnt), .acc_rvalid(lk_acc_rvalid), .acc_rdata(lk_acc_rdata),
        .acc_err(lk_acc_err),
        .mem_addr(lk_mem_addr), .mem_wrt_data(lk_mem_wrt_data), .mem_wrt_en(lk_mem_wrt_en),
        .mem_rd_data(mem_rd_data)
`ifdef ARB_PERF_CNT_EN
        , .perf_clr(perf_clr), .cpu_gnt_cnt(lk_cpu_gnt_cnt), .acc_gnt_cnt(lk_acc_gnt_cnt),
        .cpu_wait_cnt(lk_cpu_wait_cnt)
`endif
    );

    // 64-byte little-endian line starting at addr, wrapping at 64 KiB.
    function automatic logic [511:0] line_at(input logic [15:0] addr);
        logic [511:0] r;
        logic [15:0]  a;
        r = 512'h0;
        for (int i = 0; i < 64; i++) begin
            a = addr + 16'(i);
            r[i*8 +: 8] = mem[a];
        end
        return r;
    endfunction

    // Behavioural memory: 4-byte write at the edge, registered 512-bit read.
    always @(posedge clk) begin
        if (mem_wrt_en) begin
            for (int k = 0; k < 4; k++) begin
                mem[mem_addr + 16'(k)] <= mem_wrt_data[k*8 +: 8];
            end
        end
        mem_rd_data <= line_at(mem_addr);
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [15:0] addr,
                             input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic acc_drive(input logic req, input logic we, input logic [15:0] addr,
                             input logic [31:0] wdata, input logic lock);
        acc_req = req; acc_we = we; acc_addr = addr; acc_wdata = wdata; acc_lock = lock;
    endtask

    task automatic do_reset();
        cpu_drive(1'b0, 1'b0, 16'h0000, 32'h0);
        acc_drive(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    int n_acc;
    int n_lk_acc;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFD] = 8'hA5;
        mem[16'hFFC0] = 8'h11;
        mem[16'hFFFF] = 8'h3C;
        mem_rd_data = 512'h0;
        cpu_drive(1'b0, 1'b0, 16'h0000, 32'h0);
        acc_drive(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check("rst_acc_rvalid", acc_rvalid, 1'b0);
        check("rst_errs", {cpu_err, acc_err}, 2'b00);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_acc_rdata", acc_rdata, 512'h0);
        check("rst_mem_idle", {mem_addr, mem_wrt_en, cpu_gnt, acc_gnt}, 19'h0);
        rst_n = 1'b1;
        next_cycle();

        // CPU write then read back
        cpu_drive(1'b1, 1'b1, 16'h1000, 32'hDEADBEEF);
        @(negedge clk);
        check("cpu_wr_gnt", cpu_gnt, 1'b1);
        check("cpu_wr_port", {mem_wrt_en, mem_addr, mem_wrt_data}, {1'b1, 16'h1000, 32'hDEADBEEF});
        next_cycle();
        cpu_drive(1'b0, 1'b0, 16'h0000, 32'h0);
        @(negedge clk);
        check("cpu_wr_no_rvalid", cpu_rvalid, 1'b0);
        next_cycle();
        cpu_drive(1'b1, 1'b0, 16'h1000, 32'h0);
        @(negedge clk);
        check("cpu_rd_gnt", {cpu_gnt, mem_wrt_en}, 2'b10);
        next_cycle();
        cpu_drive(1'b0, 1'b0, 16'h0000, 32'h0);
        @(negedge clk);
        check("cpu_rd_rvalid", {cpu_rvalid, cpu_err}, 2'b10);
        check("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        check("cpu_rd_rvalid_drop", cpu_rvalid, 1'b0);
        check("cpu_rd_hold", cpu_rdata, 32'hDEADBEEF);
        next_cycle();

        // Accelerator writes 16 words then reads the 64-byte line
        for (int i = 0; i < 16; i++) begin
            acc_drive(1'b1, 1'b1, 16'h5000 + 16'(4 * i), 32'(i), 1'b0);
            @(negedge clk);
            check("acc_wr_gnt", {acc_gnt, mem_wrt_en}, 2'b11);
            next_cycle();
        end
        acc_drive(1'b1, 1'b0, 16'h5000, 32'h0, 1'b0);
        @(negedge clk);
        check("acc_rd_gnt", {acc_gnt, mem_wrt_en}, 2'b10);
        next_cycle();
        acc_drive(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0);
        @(negedge clk);
        check("acc_rd_rvalid", {acc_rvalid, acc_err}, 2'b10);
        check("acc_rd_w0", acc_rdata[31:0], 32'h0);
        check("acc_rd_w1", acc_rdata[63:32], 32'h1);
        check("acc_rd_w15", acc_rdata[511:480], 32'hF);
        next_cycle();
        @(negedge clk);
        check("acc_rd_rvalid_drop", acc_rvalid, 1'b0);
        check("acc_rd_hold", acc_rdata[511:480], 32'hF);
        next_cycle();

        // Out-of-range CPU write is granted but not committed
        cpu_drive(1'b1, 1'b1, 16'hFFFD, 32'h12345678);
        @(negedge clk);
        check("oor_cpu_gnt", {cpu_gnt, mem_wrt_en}, 2'b10);
        next_cycle();
        cpu_drive(1'b0, 1'b0, 16'h0000, 32'h0);
        @(negedge clk);
        check("oor_cpu_err", {cpu_rvalid, cpu_err}, 2'b11);
        next_cycle();
        @(negedge clk);
        check("oor_cpu_err_drop", {cpu_rvalid, cpu_err}, 2'b00);
        check("oor_mem_kept", mem[16'hFFFD], 8'hA5);
        next_cycle();

        // Accelerator read boundary: 0xFFC1 rejected, 0xFFC0 accepted
        acc_drive(1'b1, 1'b0, 16'hFFC1, 32'h0, 1'b0);
        @(negedge clk);
        check("oor_acc_gnt", acc_gnt, 1'b1);
        next_cycle();
        acc_drive(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0);
        @(negedge clk);
        check("oor_acc_err", {acc_rvalid, acc_err}, 2'b11);
        next_cycle();
        acc_drive(1'b1, 1'b0, 16'hFFC0, 32'h0, 1'b0);
        @(negedge clk);
        check("edge_acc_gnt", acc_gnt, 1'b1);
        next_cycle();
        acc_drive(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0);
        @(negedge clk);
        check("edge_acc_ok", {acc_rvalid, acc_err}, 2'b10);
        check("edge_acc_first", acc_rdata[7:0], 8'h11);
        check("edge_acc_last", acc_rdata[511:504], 8'h3C);
        next_cycle();

        // Reset asserted in a read's grant cycle drops the return
        cpu_drive(1'b1, 1'b0, 16'h1000, 32'h0);
        @(negedge clk);
        check("rst_mid_gnt", cpu_gnt, 1'b1);
        #1;
        rst_n = 1'b0;
        next_cycle();
        cpu_drive(1'b0, 1'b0, 16'h0000, 32'h0);
        @(negedge clk);
        check("rst_mid_no_rvalid", {cpu_rvalid, cpu_err, acc_rvalid, acc_err}, 4'h0);
        check("rst_mid_rdata", {cpu_rdata, acc_rdata}, 544'h0);
        check("rst_mid_idle", {mem_addr, mem_wrt_en, cpu_gnt, acc_gnt}, 19'h0);
        rst_n = 1'b1;
        next_cycle();

        // Both requesting, no lock: CPU, ACC, CPU, ACC with independent returns
        cpu_drive(1'b1, 1'b0, 16'h1000, 32'h0);
        acc_drive(1'b1, 1'b0, 16'h5000, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_gnt", {cpu_gnt, acc_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k == 1) check("rr_cpu_ret", {cpu_rvalid, cpu_rdata}, {1'b1, 32'hDEADBEEF});
            if (k == 2) check("rr_acc_ret", {acc_rvalid, acc_rdata[63:32]}, {1'b1, 32'h1});
            next_cycle();
        end

        // Locked accelerator with CPU waiting: starvation guard vs lock expiry
        do_reset();
        cpu_drive(1'b1, 1'b0, 16'h1000, 32'h0);
        acc_drive(1'b1, 1'b0, 16'h5000, 32'h0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("lock_starve_gnt", {cpu_gnt, acc_gnt}, (k < 8) ? 2'b01 : 2'b10);
            if (k <= 4) check("lock_expire_gnt", {lk_cpu_gnt, lk_acc_gnt}, (k < 4) ? 2'b01 : 2'b10);
            next_cycle();
        end

        // Locked accelerator alone is never preempted
        cpu_drive(1'b0, 1'b0, 16'h0000, 32'h0);
        n_acc = 0;
        n_lk_acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (acc_gnt) n_acc++;
            if (lk_acc_gnt) n_lk_acc++;
            next_cycle();
        end
        check("lock_alone_cnt", n_acc, 20);
        check("lock_alone_cnt_lk", n_lk_acc, 20);
        acc_drive(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
